// File: rtl/svf_sampler_if.sv
// svf_sampler_if: sample stream from svf_sampler to the trace/host side.
//   out_valid_o  head entry valid (driven by master)
//   out_ready_i  downstream accepts head this cycle (driven by slave)
//   out_data_o   {seq, delta}, seq in the MSBs (driven by master)
//   out_ts_o     push-edge cycle stamp, only with SVF_SAMPLER_TIMESTAMP_EN
interface svf_sampler_if #(
    parameter int unsigned SEQ_W = 8
);
    localparam int unsigned DATA_W = SEQ_W + 20;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;
`ifdef SVF_SAMPLER_TIMESTAMP_EN
    logic [31:0]       out_ts_o;

    modport master (output out_valid_o, output out_data_o, output out_ts_o, input out_ready_i);
    modport slave  (input out_valid_o, input out_data_o, input out_ts_o, output out_ready_i);
`else
    modport master (output out_valid_o, output out_data_o, input out_ready_i);
    modport slave  (input out_valid_o, input out_data_o, output out_ready_i);
`endif
endinterface

// File: rtl/svf_sampler.sv
// svf_sampler: snapshots the SPU's free-running SVF accumulator every
// programmable interval and queues {seq, delta} samples for the host.
//   clk, reset       clock; synchronous active-high reset
//   total_svf_i      20-bit running accumulator (wraps mod 2^20)
//   sample_en_i      level enable, high = sampling active
//   interval_i       cycles per sample, latched on arm (0 treated as 1)
//   out_if           valid/ready sample stream (master side)
//   drop_cnt_o       samples lost to a full FIFO, saturating at 255
//   busy_o           high while armed or running
// Optional: define SVF_SAMPLER_TIMESTAMP_EN to store a 32-bit cycle stamp
// per entry and present it on out_if.out_ts_o.
module svf_sampler #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SEQ_W      = 8,
    parameter int unsigned INTV_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [19:0]       total_svf_i,
    input  logic              sample_en_i,
    input  logic [INTV_W-1:0] interval_i,
    svf_sampler_if.master     out_if,
    output logic [7:0]        drop_cnt_o,
    output logic              busy_o
);
    localparam int unsigned SVF_W  = 20;
    localparam int unsigned DATA_W = SEQ_W + SVF_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SVF_W-1:0]   base_q, base_d;
    logic [INTV_W-1:0]  intv_q, intv_d;
    logic [INTV_W-1:0]  cnt_q, cnt_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               busy_q;
    logic               push_req;
    logic [SVF_W-1:0]   delta;
    logic [DATA_W-1:0]  push_data;

    // Shift-register FIFO: entry 0 is always the head, so the output is a flop.
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic [7:0]         drop_q, drop_d;
    logic               pop, full, push_ok;
    logic [PTR_W-1:0]   wr_idx;

`ifdef SVF_SAMPLER_TIMESTAMP_EN
    logic [31:0]        ts_q;
    logic [31:0]        ts_mem_q [FIFO_DEPTH];
    logic [31:0]        ts_mem_d [FIFO_DEPTH];
`endif

    // Sampling FSM: arm latches baseline/interval, run emits one delta per interval.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        intv_d   = intv_q;
        cnt_d    = cnt_q;
        seq_d    = seq_q;
        push_req = 1'b0;
        delta    = total_svf_i - base_q;
        push_data = {seq_q, delta};
        unique case (state_q)
            ST_IDLE: begin
                if (sample_en_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                base_d  = total_svf_i;
                intv_d  = (interval_i == '0) ? INTV_W'(1) : interval_i;
                cnt_d   = '0;
                state_d = sample_en_i ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!sample_en_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == intv_q - INTV_W'(1)) begin
                    // Sequence advances even if the FIFO drops the sample.
                    push_req = 1'b1;
                    base_d   = total_svf_i;
                    cnt_d    = '0;
                    seq_d    = seq_q + SEQ_W'(1);
                end else begin
                    cnt_d = cnt_q + INTV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO next state; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        pop     = valid_q && out_if.out_ready_i;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok = push_req && (!full || pop);
        wr_idx  = pop ? PTR_W'(count_q - CNT_W'(1)) : PTR_W'(count_q);
        mem_d   = mem_q;
        if (pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) mem_d[i] = mem_q[i+1];
        end
        if (push_ok) mem_d[wr_idx] = push_data;
`ifdef SVF_SAMPLER_TIMESTAMP_EN
        ts_mem_d = ts_mem_q;
        if (pop) begin
            for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) ts_mem_d[i] = ts_mem_q[i+1];
        end
        if (push_ok) ts_mem_d[wr_idx] = ts_q;
`endif
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        valid_d = (count_d != '0);
        drop_d  = drop_q;
        if (push_req && !push_ok && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            intv_q  <= INTV_W'(1);
            cnt_q   <= '0;
            seq_q   <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            drop_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
`ifdef SVF_SAMPLER_TIMESTAMP_EN
            ts_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) ts_mem_q[i] <= '0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            intv_q  <= intv_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            busy_q  <= (state_d != ST_IDLE);
            count_q <= count_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            mem_q   <= mem_d;
`ifdef SVF_SAMPLER_TIMESTAMP_EN
            ts_q     <= ts_q + 32'd1;
            ts_mem_q <= ts_mem_d;
`endif
        end
    end

    assign out_if.out_valid_o = valid_q;
    assign out_if.out_data_o  = mem_q[0];
`ifdef SVF_SAMPLER_TIMESTAMP_EN
    assign out_if.out_ts_o    = ts_mem_q[0];
`endif
    assign drop_cnt_o = drop_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_svf_sampler.sv
// tb_svf_sampler: table-driven and hand-written checks for svf_sampler,
// plus randomized stimulus compared every cycle against a queue-based model.
module tb_svf_sampler;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned SEQ_W      = 8;
    localparam int unsigned INTV_W     = 16;
    localparam int unsigned DATA_W     = SEQ_W + 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [19:0]       svf = '0;
    logic              en = 1'b0;
    logic [INTV_W-1:0] intv = '0;
    logic              ready = 1'b0;
    logic [7:0]        drop_cnt;
    logic              busy;

    svf_sampler_if #(.SEQ_W(SEQ_W)) sif ();
    assign sif.out_ready_i = ready;

    svf_sampler #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .SEQ_W     (SEQ_W),
        .INTV_W    (INTV_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .total_svf_i(svf),
        .sample_en_i(en),
        .interval_i (intv),
        .out_if     (sif),
        .drop_cnt_o (drop_cnt),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode 0 = idle, 1 = arming, 2 = sampling.
    int                m_mode = 0;
    logic [19:0]       m_base = '0;
    int                m_intv = 1;
    int                m_elapsed = 0;
    int                m_seq = 0;
    int                m_drop = 0;
    longint            m_ts = 0;
    logic [DATA_W-1:0] m_q [$];
    longint            m_tq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        logic              pop;
        logic              push;
        logic [19:0]       d;
        logic [DATA_W-1:0] pd;
        push = 1'b0;
        pd   = '0;
        if (reset) begin
            m_mode = 0; m_base = '0; m_intv = 1; m_elapsed = 0;
            m_seq = 0; m_drop = 0; m_ts = 0;
            m_q.delete(); m_tq.delete();
            return;
        end
        pop = (m_q.size() != 0) && ready;
        case (m_mode)
            0: if (en) m_mode = 1;
            1: begin
                m_base    = svf;
                m_intv    = (intv == 0) ? 1 : int'(intv);
                m_elapsed = 0;
                m_mode    = en ? 2 : 0;
            end
            default: begin
                if (!en) m_mode = 0;
                else begin
                    m_elapsed++;
                    if (m_elapsed == m_intv) begin
                        d = svf - m_base;
                        pd = {SEQ_W'(m_seq), d};
                        push = 1'b1;
                        m_base = svf;
                        m_elapsed = 0;
                        m_seq = (m_seq + 1) % 256;
                    end
                end
            end
        endcase
        if (pop) begin
            void'(m_q.pop_front());
            void'(m_tq.pop_front());
        end
        if (push) begin
            if (m_q.size() < FIFO_DEPTH) begin
                m_q.push_back(pd);
                m_tq.push_back(m_ts);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        m_ts++;
    endtask

    task automatic check_model();
        check("model_valid", 64'(sif.out_valid_o), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("model_data", 64'(sif.out_data_o), 64'(m_q[0]));
`ifdef SVF_SAMPLER_TIMESTAMP_EN
            check("model_ts", 64'(sif.out_ts_o), 64'(m_tq[0]));
`endif
        end
        check("model_drop", 64'(drop_cnt), 64'(m_drop));
        check("model_busy", 64'(busy), 64'(m_mode != 0));
    endtask

    // One clock: inputs already stable, model follows the edge, sample on negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0; ready = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic check_head(input string name, input int seq, input int dl);
        logic [DATA_W-1:0] e;
        e = {SEQ_W'(seq), 20'(dl)};
        check({name, "_valid"}, 64'(sif.out_valid_o), 64'd1);
        check({name, "_data"}, 64'(sif.out_data_o), 64'(e));
    endtask

    typedef struct {
        logic              en;
        logic              ready;
        logic [19:0]       svf;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic              exp_busy;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // Basic interval: interval 4, +10 per cycle, always ready.
        for (int k = 0; k < 14; k++) begin
            tbl[k].en        = 1'b1;
            tbl[k].ready     = 1'b1;
            tbl[k].svf       = 20'(100 + 10 * k);
            tbl[k].exp_valid = (k == 5 || k == 9 || k == 13);
            tbl[k].exp_data  = {SEQ_W'((k - 5) / 4), 20'd40};
            tbl[k].exp_busy  = 1'b1;
        end

        @(negedge clk);
        do_reset();
        check("rst_valid", 64'(sif.out_valid_o), 64'd0);
        check("rst_data", 64'(sif.out_data_o), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
`ifdef SVF_SAMPLER_TIMESTAMP_EN
        check("rst_ts", 64'(sif.out_ts_o), 64'd0);
`endif

        intv = 16'd4;
        for (int k = 0; k < 14; k++) begin
            en = tbl[k].en; ready = tbl[k].ready; svf = tbl[k].svf;
            step();
            check("tbl_valid", 64'(sif.out_valid_o), 64'(tbl[k].exp_valid));
            check("tbl_busy", 64'(busy), 64'(tbl[k].exp_busy));
            if (tbl[k].exp_valid) check("tbl_data", 64'(sif.out_data_o), 64'(tbl[k].exp_data));
        end

        // Accumulator wrap: baseline 0xFFFF0, 0x00010 at expiry.
        do_reset();
        intv = 16'd2; en = 1'b1; svf = 20'h12345;
        step();
        svf = 20'hFFFF0; step();
        svf = 20'h00000; step();
        svf = 20'h00010; step();
        check_head("wrap", 0, 32'h20);
        en = 1'b0; step();

        // Backpressure: 12 samples into 8 entries.
        do_reset();
        intv = 16'd1; en = 1'b1; svf = '0;
        step(); step();
        for (int i = 0; i < 12; i++) begin
            svf = svf + 20'd7;
            step();
            check_head("bp_hold", 0, 7);
        end
        check("bp_drop", 64'(drop_cnt), 64'd4);
        en = 1'b0; step();
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_head("bp_drain", i, 7);
            step();
        end
        check("bp_empty", 64'(sif.out_valid_o), 64'd0);
        check("bp_drop_kept", 64'(drop_cnt), 64'd4);

        // Push and pop together while full.
        do_reset();
        intv = 16'd1; en = 1'b1; svf = '0;
        step(); step();
        for (int i = 0; i < 8; i++) begin
            svf = svf + 20'd3; step();
        end
        ready = 1'b1; svf = svf + 20'd3; step();
        check("pp_drop", 64'(drop_cnt), 64'd0);
        check_head("pp_head", 1, 3);
        en = 1'b0; ready = 1'b0; step();
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check_head("pp_drain", i, 3);
            step();
        end
        check("pp_empty", 64'(sif.out_valid_o), 64'd0);

        // Disable mid-interval, then re-enable with interval 0.
        do_reset();
        intv = 16'd10; en = 1'b1; ready = 1'b1; svf = '0;
        for (int i = 0; i < 7; i++) begin
            svf = svf + 20'd5; step();
        end
        en = 1'b0; svf = svf + 20'd5; step();
        check("dis_busy", 64'(busy), 64'd0);
        check("dis_valid", 64'(sif.out_valid_o), 64'd0);
        en = 1'b1; intv = 16'd0;
        svf = svf + 20'd5; step();
        svf = svf + 20'd5; step();
        svf = svf + 20'd5; step();
        check_head("int0_first", 0, 5);
        svf = svf + 20'd5; step();
        check_head("int0_second", 1, 5);
        en = 1'b0; step();

        // Reset mid-run with three entries queued.
        do_reset();
        intv = 16'd1; en = 1'b1; ready = 1'b0; svf = '0;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            svf = svf + 20'd9; step();
        end
        reset = 1'b1; step();
        check("mrst_valid", 64'(sif.out_valid_o), 64'd0);
        check("mrst_drop", 64'(drop_cnt), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step(); step();
        svf = svf + 20'd9; step();
        check_head("mrst_seq0", 0, 9);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            int ph;
            ph = (c / 200) % 3;
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 31) == 0) intv = INTV_W'($urandom_range(0, 6));
            case (ph)
                0: ready = ($urandom_range(0, 3) != 0);
                1: ready = ($urandom_range(0, 7) == 0);
                default: ready = $urandom_range(0, 1) != 0;
            endcase
            if ($urandom_range(0, 63) == 0) svf = svf + 20'($urandom_range(0, 1048575));
            else svf = svf + 20'($urandom_range(0, 50));
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/svf_sampler.md
Name: svf_sampler

Overview:
- Consumer of the SPU's running SVF accumulator (total_svf, 20-bit, free-running, wraps mod 2^20).
- Every programmable interval it snapshots the accumulator and computes the per-interval delta.
- Each delta is tagged with a sequence number and queued in a small FIFO.
- The FIFO drains over a valid/ready stream to the trace/host interface, so SVF can be profiled over time instead of only read as a final total.

Parameters:
- FIFO_DEPTH, 8, number of sample entries buffered; power of two, >= 2.
- SEQ_W, 8, width of sample sequence number.
- INTV_W, 16, width of interval length.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- total_svf_i  input  20  running SVF accumulator from SPU.
- sample_en_i  input  1  level enable; high = sampling active.
- interval_i  input  INTV_W  cycles per sample; latched on arm.
- out_valid_o  output  1  FIFO head valid.
- out_ready_i  input  1  downstream accepts head this cycle.
- out_data_o  output  SEQ_W+20  {seq, delta}; seq in MSBs.
- drop_cnt_o  output  8  samples dropped due to full FIFO; saturating.
- busy_o  output  1  high in ARM or RUN.

Behaviour:
- Reset values:
  - out_valid_o=0, out_data_o=0, drop_cnt_o=0, busy_o=0.
  - FSM=IDLE, FIFO empty, seq=0, cycle counter=0, baseline=0.
- FSM states: IDLE, ARM, RUN.
- IDLE:
  - Exits to ARM when sample_en_i=1.
  - FIFO contents remain drainable.
- ARM (exactly one cycle):
  - baseline <= total_svf_i.
  - intv_q <= interval_i, except interval_i==0 latches as 1.
  - cnt <= 0.
  - Next state RUN.
  - If sample_en_i drops while in ARM, next state is IDLE.
- RUN:
  - cnt increments every cycle.
  - When cnt==intv_q-1: delta = total_svf_i - baseline (20-bit modular subtraction; accumulator wrap yields correct delta), push {seq, delta}, baseline <= total_svf_i, cnt <= 0, seq <= seq+1 (wraps at 2^SEQ_W).
  - sample_en_i=0 in RUN: next state IDLE; the partial interval is discarded, no push.
  - Re-enable re-arms with a fresh baseline.
  - seq is NOT reset on re-arm, only by reset.
  - interval_i changes in RUN are ignored until the next ARM.
- Push latency: a sample pushed at edge N is visible on out_valid_o/out_data_o after edge N if the FIFO was empty (registered outputs, no fall-through).
- Handshake:
  - Head is popped on the edge where out_valid_o && out_ready_i.
  - out_data_o holds stable while out_valid_o=1 and out_ready_i=0.
- Full FIFO:
  - A push with no simultaneous pop is dropped.
  - drop_cnt_o increments, saturating at 255.
  - seq still increments, so the host sees the gap.
  - A push and a pop in the same cycle when full: push accepted, no drop.
- Empty FIFO: out_ready_i is ignored.
- busy_o = (state != IDLE).
- Reset mid-operation: all state returns to reset values on the next edge; FIFO contents are lost.

Optional Feature:
- Macro SVF_SAMPLER_TIMESTAMP_EN.
- Defined:
  - A free-running 32-bit cycle counter runs from reset.
  - Each FIFO entry additionally stores the counter value at the push edge.
  - Extra output port out_ts_o [31:0] is aligned with out_data_o and obeys the same hold rules.
  - Reset value of out_ts_o is 0.
- Undefined:
  - Port and counter are absent.
  - FIFO width is SEQ_W+20.
  - Behaviour is otherwise identical.

Test Plan:
- Basic interval: interval_i=4, enable at t0, total_svf_i increasing by 10/cycle, out_ready_i=1 -> samples {0,40},{1,40},{2,40}, one every 4 cycles after the ARM cycle.
- Accumulator wrap: baseline 0xFFFF0, total_svf_i reaches 0x00010 at expiry -> delta = 0x00020.
- Backpressure/full: FIFO_DEPTH=8, out_ready_i=0, interval_i=1 for 12 samples -> 8 entries held (seq 0..7 in order), drop_cnt_o=4, out_data_o stable; then ready=1 drains seq 0..7.
- Simultaneous push/pop at full: FIFO full, pop and expiry same cycle -> no drop, occupancy stays 8, new entry at tail.
- Disable mid-interval: interval_i=10, drop sample_en_i at cnt=5 -> no push, busy_o=0 next cycle; re-enable -> fresh baseline, next seq continues; interval_i=0 -> sample every cycle.
- Reset mid-run with 3 queued entries -> next cycle out_valid_o=0, drop_cnt_o=0, seq restarts at 0; with SVF_SAMPLER_TIMESTAMP_EN, out_ts_o timestamps differ by exactly intv_q.
